// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard controller: register address width,
// forwarding select encodings and FSM state encodings.
package ex_hazard_ctrl_pkg;

    localparam int GRP_ADDR_WIDTH = 5;

    typedef logic [GRP_ADDR_WIDTH-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FOWARD_NONE = 2'b00,
        FOWARD_EX   = 2'b01,
        FOWARD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_IDLE    = 1'b0,
        HZ_MC_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle of pipeline-register fields observed by the hazard controller and the
// enable/select signals it returns to the pipeline.
interface ex_hazard_ctrl_if;
    import ex_hazard_ctrl_pkg::*;

    reg_addr_t   id_rs;
    reg_addr_t   id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    reg_addr_t   ex_rs;
    reg_addr_t   ex_rt;
    reg_addr_t   ex_reg_dest;
    logic        ex_reg_write_enable;
    logic        ex_is_load;
    reg_addr_t   mem_reg_dest;
    logic        mem_reg_write_enable;
    reg_addr_t   wb_reg_dest;
    logic        wb_reg_write_enable;
    logic        ex_mc_start;
    logic        branch_taken;

    logic [1:0]  fowardA;
    logic [1:0]  fowardB;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        ex_hold;
    logic        exmem_bubble;
    logic        mc_done;
    logic        busy;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt,
               ex_reg_dest, ex_reg_write_enable, ex_is_load,
               mem_reg_dest, mem_reg_write_enable, wb_reg_dest, wb_reg_write_enable,
               ex_mc_start, branch_taken,
        input  fowardA, fowardB, pc_stall, ifid_stall, idex_bubble,
               ex_hold, exmem_bubble, mc_done, busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt,
               ex_reg_dest, ex_reg_write_enable, ex_is_load,
               mem_reg_dest, mem_reg_write_enable, wb_reg_dest, wb_reg_write_enable,
               ex_mc_start, branch_taken,
        output fowardA, fowardB, pc_stall, ifid_stall, idex_bubble,
               ex_hold, exmem_bubble, mc_done, busy
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// Operand forwarding compare for one EX source register; the younger EX/MEM
// result takes precedence over MEM/WB.
module ex_hazard_ctrl_fwd_select
    import ex_hazard_ctrl_pkg::*;
(
    input  reg_addr_t src,
    input  reg_addr_t mem_dest,
    input  logic      mem_we,
    input  reg_addr_t wb_dest,
    input  logic      wb_we,
    output fwd_sel_e  sel
);

    always_comb begin
        if (mem_we && (mem_dest == src)) begin
            sel = FOWARD_EX;
        end else if (wb_we && (wb_dest == src)) begin
            sel = FOWARD_MEM;
        end else begin
            sel = FOWARD_NONE;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects, load-use stall and a
// fixed-latency multi-cycle op sequencer, all overridden by a taken branch.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    ex_hazard_ctrl_if.slave   bus
);

    localparam int               CNT_W    = $clog2(MC_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);

    fwd_sel_e         fwd_a;
    fwd_sel_e         fwd_b;
    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             lu_stall;
    logic             mc_hold;
    logic             mc_last;

    ex_hazard_ctrl_fwd_select u_fwd_a (
        .src      (bus.ex_rs),
        .mem_dest (bus.mem_reg_dest),
        .mem_we   (bus.mem_reg_write_enable),
        .wb_dest  (bus.wb_reg_dest),
        .wb_we    (bus.wb_reg_write_enable),
        .sel      (fwd_a)
    );

    ex_hazard_ctrl_fwd_select u_fwd_b (
        .src      (bus.ex_rt),
        .mem_dest (bus.mem_reg_dest),
        .mem_we   (bus.mem_reg_write_enable),
        .wb_dest  (bus.wb_reg_dest),
        .wb_we    (bus.wb_reg_write_enable),
        .sel      (fwd_b)
    );

    assign load_use = bus.ex_is_load && bus.ex_reg_write_enable &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_reg_dest)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_reg_dest)));

    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lu_stall = 1'b0;
        mc_hold  = 1'b0;
        mc_last  = 1'b0;
        case (state_q)
            HZ_IDLE: begin
                if (bus.branch_taken) begin
                    cnt_d = '0;
                end else if (bus.ex_mc_start) begin
                    // Holding ID/EX already keeps the dependent instruction in ID,
                    // so a coincident load-use hazard needs no bubble here.
                    mc_hold = 1'b1;
                    state_d = HZ_MC_BUSY;
                    cnt_d   = CNT_LOAD;
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end
            end
            HZ_MC_BUSY: begin
                if (bus.branch_taken) begin
                    state_d = HZ_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    mc_hold = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    mc_last = 1'b1;
                    state_d = HZ_IDLE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control outputs are qualified by rst_n so an asserted reset silences
    // them immediately, even while the EX-side inputs still look active.
    assign bus.fowardA      = fwd_a;
    assign bus.fowardB      = fwd_b;
    assign bus.pc_stall     = rst_n && (lu_stall || mc_hold);
    assign bus.ifid_stall   = rst_n && (lu_stall || mc_hold);
    assign bus.idex_bubble  = rst_n && lu_stall;
    assign bus.ex_hold      = rst_n && mc_hold;
    assign bus.exmem_bubble = rst_n && mc_hold;
    assign bus.mc_done      = rst_n && mc_last;
    assign bus.busy         = (state_q == HZ_MC_BUSY);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-count model of the hazard rules.
module tb_ex_hazard_ctrl;

    localparam int L = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mc_left = 0;   // model: busy cycles still to come, including the current one

    always #5 clk = ~clk;

    ex_hazard_ctrl_if bus ();

    ex_hazard_ctrl #(.MC_LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic [4:0] md,
                                           input logic mwe, input logic [4:0] wd,
                                           input logic wwe);
        if (mwe && md == src) return 2'b01;
        if (wwe && wd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [15:0] dut_outs();
        return {5'd0, bus.fowardA, bus.fowardB, bus.pc_stall, bus.ifid_stall,
                bus.idex_bubble, bus.ex_hold, bus.exmem_bubble, bus.mc_done, bus.busy};
    endfunction

    // Expected outputs for the present inputs, plus the model's next mc_left.
    task automatic model(output logic [15:0] exp, output int nxt);
        logic stall, bub, hold, done, ld_use;
        stall = 1'b0; bub = 1'b0; hold = 1'b0; done = 1'b0;
        nxt = mc_left;
        ld_use = bus.ex_is_load && bus.ex_reg_write_enable &&
                 ((bus.id_uses_rs && bus.id_rs == bus.ex_reg_dest) ||
                  (bus.id_uses_rt && bus.id_rt == bus.ex_reg_dest));
        if (!rst_n)                nxt = 0;
        else if (bus.branch_taken) nxt = 0;
        else if (mc_left > 1)      begin hold = 1'b1; nxt = mc_left - 1; end
        else if (mc_left == 1)     begin done = 1'b1; nxt = 0; end
        else if (bus.ex_mc_start)  begin hold = 1'b1; nxt = L - 1; end
        else if (ld_use)           begin stall = 1'b1; bub = 1'b1; end
        exp = {5'd0,
               ref_fwd(bus.ex_rs, bus.mem_reg_dest, bus.mem_reg_write_enable,
                       bus.wb_reg_dest, bus.wb_reg_write_enable),
               ref_fwd(bus.ex_rt, bus.mem_reg_dest, bus.mem_reg_write_enable,
                       bus.wb_reg_dest, bus.wb_reg_write_enable),
               stall | hold, stall | hold, bub, hold, hold, done,
               rst_n && (mc_left > 0)};
    endtask

    // Inputs are already driven; check mid-cycle, then advance one clock.
    task automatic cycle(input string tag);
        logic [15:0] exp;
        int nxt;
        #2;
        model(exp, nxt);
        check(tag, dut_outs(), exp);
        @(posedge clk);
        #1;
        mc_left = nxt;
    endtask

    task automatic clear_inputs();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
        bus.ex_rs = 5'd30; bus.ex_rt = 5'd31;
        bus.ex_reg_dest = '0; bus.ex_reg_write_enable = 1'b0; bus.ex_is_load = 1'b0;
        bus.mem_reg_dest = '0; bus.mem_reg_write_enable = 1'b0;
        bus.wb_reg_dest = '0; bus.wb_reg_write_enable = 1'b0;
        bus.ex_mc_start = 1'b0; bus.branch_taken = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #3;
        check("reset_outputs", dut_outs(), {5'd0, 4'b0000, 7'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Forwarding priority
        bus.mem_reg_dest = 5'd3; bus.mem_reg_write_enable = 1'b1;
        bus.wb_reg_dest = 5'd3;  bus.wb_reg_write_enable = 1'b1;
        bus.ex_rs = 5'd3; bus.ex_rt = 5'd5;
        #1;
        check("fwdA_ex", {14'd0, bus.fowardA}, 16'd1);
        check("fwdB_none", {14'd0, bus.fowardB}, 16'd0);
        cycle("fwd_ex_wins");
        bus.mem_reg_write_enable = 1'b0;
        #1;
        check("fwdA_mem", {14'd0, bus.fowardA}, 16'd2);
        cycle("fwd_mem");
        clear_inputs();

        // Load-use stall for exactly one cycle, then the load leaves EX
        bus.ex_is_load = 1'b1; bus.ex_reg_write_enable = 1'b1; bus.ex_reg_dest = 5'd7;
        bus.id_rs = 5'd7; bus.id_uses_rs = 1'b1;
        #1;
        check("lu_bubble", {15'd0, bus.idex_bubble}, 16'd1);
        cycle("lu_stall");
        clear_inputs();
        cycle("lu_released");
        bus.ex_is_load = 1'b1; bus.ex_reg_write_enable = 1'b1; bus.ex_reg_dest = 5'd7;
        bus.id_rs = 5'd7; bus.id_uses_rs = 1'b0;
        cycle("lu_unused_rs");
        clear_inputs();

        // Full multi-cycle op
        bus.ex_mc_start = 1'b1;
        cycle("mc_c0");
        bus.ex_mc_start = 1'b0;
        cycle("mc_c1");
        cycle("mc_c2");
        #1;
        check("mc_done_c3", {15'd0, bus.mc_done}, 16'd1);
        cycle("mc_c3");
        cycle("mc_idle_after");

        // Branch during cycle 1 aborts the op
        bus.ex_mc_start = 1'b1;
        cycle("br_c0");
        bus.ex_mc_start = 1'b0; bus.branch_taken = 1'b1;
        cycle("br_c1");
        bus.branch_taken = 1'b0;
        cycle("br_c2");
        cycle("br_c3");
        cycle("br_c4");

        // Asynchronous reset in cycle 2, then a fresh op
        bus.ex_mc_start = 1'b1;
        cycle("rst_c0");
        bus.ex_mc_start = 1'b0;
        cycle("rst_c1");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", dut_outs(), {5'd0, 4'b0000, 7'b0});
        cycle("rst_held");
        rst_n = 1'b1;
        bus.ex_mc_start = 1'b1;
        cycle("fresh_c0");
        bus.ex_mc_start = 1'b0;
        for (int i = 1; i < L; i++) cycle("fresh_cN");
        cycle("fresh_idle");

        // Multi-cycle start coincident with a persisting load-use hazard
        bus.ex_is_load = 1'b1; bus.ex_reg_write_enable = 1'b1; bus.ex_reg_dest = 5'd9;
        bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1; bus.ex_mc_start = 1'b1;
        #1;
        check("mc_lu_bubble0", {15'd0, bus.idex_bubble}, 16'd0);
        check("mc_lu_hold1", {15'd0, bus.ex_hold}, 16'd1);
        cycle("mc_lu_c0");
        bus.ex_mc_start = 1'b0;
        for (int i = 1; i < L; i++) cycle("mc_lu_cN");
        #1;
        check("lu_after_done", {15'd0, bus.idex_bubble}, 16'd1);
        cycle("lu_after_done_cyc");
        clear_inputs();
        cycle("quiet");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rs = 1'($urandom);
            bus.id_uses_rt = 1'($urandom);
            bus.ex_rs = 5'($urandom_range(0, 3));
            bus.ex_rt = 5'($urandom_range(0, 3));
            bus.ex_reg_dest = 5'($urandom_range(0, 3));
            bus.ex_reg_write_enable = 1'($urandom);
            bus.ex_is_load = 1'($urandom);
            bus.mem_reg_dest = 5'($urandom_range(0, 3));
            bus.mem_reg_write_enable = 1'($urandom);
            bus.wb_reg_dest = 5'($urandom_range(0, 3));
            bus.wb_reg_write_enable = 1'($urandom);
            bus.ex_mc_start = ($urandom_range(0, 3) == 0);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 47) != 0);
            cycle("random");
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
